pair_triple_window_detector: RTL and testbench
==============================================

Name: pair_triple_window_detector

Overview:
- Sequential, parametrised successor to the combinational pair/triple detector.
- Each accepted sample is an NBITS-wide vector. It is a "hit" when its popcount is at least MIN_ONES. With defaults NBITS=3, MIN_ONES=2 this is the pair-or-triple condition.
- A sliding window holds the hit flags of the last DEPTH accepted samples. The block reports when the number of hits in the window reaches THRESH.
- Sits in the lab datapath downstream of input sampling logic. Output is registered, with a valid flag.

Parameters:
- NBITS, 3: width of each input sample.
- MIN_ONES, 2: minimum number of ones for a sample to count as a hit. Legal range 1..NBITS.
- DEPTH, 4: window length in accepted samples. Legal range 2..16.
- THRESH, 2: number of hits in the window needed to assert out. Legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_val  input  1  in_bits is a valid sample this cycle.
- in_bits  input  NBITS  sample vector.
- clear  input  1  synchronous window flush.
- out_val  output  1  registered; out/count are meaningful this cycle.
- out  output  1  registered; window hit count >= THRESH.
- count  output  $clog2(DEPTH+1)  registered number of hits in the current window.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - window flags, sample counter, count, out, out_val all go to 0.
  - FSM goes to FILL.
  - Takes effect immediately, without waiting for a clock edge.
- hit = (popcount(in_bits) >= MIN_ONES). Computed combinationally from in_bits.
- An accept happens on a rising edge when in_val=1 and clear=0. On accept:
  - the window shifts by one; the new hit flag enters and the oldest flag is evicted.
  - count_next = count + hit - evicted_flag. Evaluated at full width, never wraps, and always stays in 0..DEPTH.
- In-flight sample is not a handshake: there is no ready signal, and every valid sample is accepted unless clear is high.
- FSM, two states:
  - FILL: counts accepted samples in a counter of $clog2(DEPTH+1) bits. When the DEPTH-th sample since reset/clear is accepted, go to RUN.
  - RUN: stays in RUN until clear or reset.
- Outputs are registered, with 1-cycle latency. On the edge that accepts a sample:
  - out_val is set to 1 if the post-accept state is RUN, i.e. the window is full including this sample. Otherwise out_val is set to 0.
  - count is set to count_next.
  - out is set to (count_next >= THRESH) and is qualified by out_val.
- Cycles with no accept: out_val is 0 on the next cycle; count and out hold their last values.
- clear=1 on an edge:
  - window flags, sample counter, count and out go to 0; out_val goes to 0; FSM goes to FILL.
  - clear has priority over a simultaneous in_val; that sample is discarded.
- Flags evicted during FILL are 0 (reset/cleared). Partial-window counts are therefore exact.
- Parameter legality is checked at elaboration. An illegal value triggers $error.

Optional Feature:
- Macro: PAIR_TRIPLE_HIT_CNT_EN.
- When defined:
  - adds an output hit_cnt, 8 bits wide.
  - hit_cnt increments on every edge where the registered out_val and out are both 1.
  - saturates at 255.
  - reset to 0 by rst_n and by clear.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan (defaults NBITS=3, MIN_ONES=2, DEPTH=4, THRESH=2):
1. Hold rst_n=0 and toggle inputs. Then release rst_n mid-cycle. Required: out_val=0, out=0, count=0 throughout.
2. Accept 011, 000, 000 on consecutive cycles. Required: out_val=0 after each. Then accept 111. Required: next cycle out_val=1, count=2, out=1.
3. From step 2, accept 000. Required: window {000,000,111,000}, count=1, out=0, out_val=1. Then accept 110. Required: count=2, out=1.
4. Hold in_val=0 for 3 cycles in RUN. Required: out_val=0, count and out unchanged. The next accept resumes with out_val=1.
5. Assert clear and in_val=1 with sample 111 in the same cycle. Required: count=0, out_val=0, FSM in FILL, sample discarded. Then 4 fresh accepts are needed before out_val=1 again.
6. Pulse rst_n low asynchronously mid-RUN with count=3. Required: all outputs are 0 before the next clk edge. With PAIR_TRIPLE_HIT_CNT_EN defined, hit_cnt=0 after reset and saturates at 255 after 300 consecutive hit cycles.

Source files
------------

// File: rtl/pair_triple_window_detector_if.sv
// Sample/result bundle for pair_triple_window_detector.
// The hit_cnt signal exists only when PAIR_TRIPLE_HIT_CNT_EN is defined.
interface pair_triple_window_detector_if #(
    parameter int NBITS = 3,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_val;
    logic [NBITS-1:0] in_bits;
    logic             clear;
    logic             out_val;
    logic             out;
    logic [CW-1:0]    count;
`ifdef PAIR_TRIPLE_HIT_CNT_EN
    logic [7:0]       hit_cnt;

    modport master (output in_val, in_bits, clear,
                    input  out_val, out, count, hit_cnt);
    modport slave  (input  in_val, in_bits, clear,
                    output out_val, out, count, hit_cnt);
`else
    modport master (output in_val, in_bits, clear,
                    input  out_val, out, count);
    modport slave  (input  in_val, in_bits, clear,
                    output out_val, out, count);
`endif
endinterface

// File: rtl/pair_triple_window_detector.sv
// pair_triple_window_detector: sliding-window hit counter.
// A sample is a hit when popcount >= MIN_ONES; out asserts when the last
// DEPTH accepted samples hold at least THRESH hits. Outputs registered,
// one cycle after the accepting edge.
// Optional: define PAIR_TRIPLE_HIT_CNT_EN to add the saturating hit_cnt output.
module pair_triple_window_detector #(
    parameter int NBITS    = 3,
    parameter int MIN_ONES = 2,
    parameter int DEPTH    = 4,
    parameter int THRESH   = 2
) (
    input  logic clk,
    input  logic rst_n,
    pair_triple_window_detector_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(NBITS + 1);

    // Elaboration-time parameter legality
    if (MIN_ONES < 1 || MIN_ONES > NBITS) begin : g_bad_min_ones
        $error("pair_triple_window_detector: MIN_ONES=%0d out of 1..NBITS", MIN_ONES);
    end
    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("pair_triple_window_detector: DEPTH=%0d out of 2..16", DEPTH);
    end
    if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
        $error("pair_triple_window_detector: THRESH=%0d out of 1..DEPTH", THRESH);
    end

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  fill_q, fill_d;
    logic [DEPTH-1:0] win_q;     // win_q[DEPTH-1] is the oldest flag
    logic [PW-1:0]  ones;
    logic           hit;
    logic           accept;
    logic [CW:0]    count_next_w;
    logic [CW-1:0]  count_next;
    logic [CW-1:0]  count_q;
    logic           out_q;
    logic           out_val_q;

    // Popcount of the incoming sample and hit decision
    always_comb begin
        ones = '0;
        for (int i = 0; i < NBITS; i++)
            ones = ones + PW'(bus.in_bits[i]);
        hit = (ones >= PW'(MIN_ONES));
    end

    // Accept qualification and the next window count; one bit of headroom
    // keeps the add/subtract exact before truncating back to CW bits
    always_comb begin
        accept       = bus.in_val && !bus.clear;
        count_next_w = {1'b0, count_q} + (CW+1)'(hit) - (CW+1)'(win_q[DEPTH-1]);
        count_next   = count_next_w[CW-1:0];
    end

    // FSM next state: FILL counts accepts until the window is full
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (bus.clear) begin
            state_d = FILL;
            fill_d  = '0;
        end else if (accept && state_q == FILL) begin
            fill_d = fill_q + CW'(1);
            if (fill_q == CW'(DEPTH - 1))
                state_d = RUN;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Window shift register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            count_q   <= '0;
            out_q     <= 1'b0;
            out_val_q <= 1'b0;
        end else if (bus.clear) begin
            win_q     <= '0;
            count_q   <= '0;
            out_q     <= 1'b0;
            out_val_q <= 1'b0;
        end else if (accept) begin
            win_q     <= {win_q[DEPTH-2:0], hit};
            count_q   <= count_next;
            out_q     <= (count_next >= CW'(THRESH));
            out_val_q <= (state_d == RUN);
        end else begin
            out_val_q <= 1'b0;
        end
    end

    assign bus.out_val = out_val_q;
    assign bus.out     = out_q;
    assign bus.count   = count_q;

`ifdef PAIR_TRIPLE_HIT_CNT_EN
    logic [7:0] hit_cnt_q;

    // Saturating count of cycles presenting a valid asserted out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_cnt_q <= '0;
        else if (bus.clear)
            hit_cnt_q <= '0;
        else if (out_val_q && out_q && hit_cnt_q != 8'hFF)
            hit_cnt_q <= hit_cnt_q + 8'd1;
    end

    assign bus.hit_cnt = hit_cnt_q;
`endif
endmodule

// File: tb/tb_pair_triple_window_detector.sv
// Scoreboard bench for pair_triple_window_detector (default parameters).
// Driver updates a queue-based window model and pushes the expected
// registered outputs for each clock; the monitor pops and compares.
module tb_pair_triple_window_detector;
    localparam int NB = 3, MINO = 2, DEP = 4, TH = 2;
    localparam int CW = $clog2(DEP + 1);

    typedef struct {
        logic          v;
        logic          o;
        logic [CW-1:0] c;
        logic [7:0]    hc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pair_triple_window_detector_if #(.NBITS(NB), .DEPTH(DEP)) bus ();

    pair_triple_window_detector #(
        .NBITS(NB), .MIN_ONES(MINO), .DEPTH(DEP), .THRESH(TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model state: hit flags of accepted samples since reset/clear
    bit   win[$];
    int   nacc;
    exp_t cur;

    function automatic void model_reset();
        win.delete();
        nacc = 0;
        cur.v = 0; cur.o = 0; cur.c = '0; cur.hc = '0;
    endfunction

    // Advance the model across one clock edge with the given inputs
    function automatic void model_edge(input logic v, input logic [NB-1:0] b, input logic clr);
        int   sum;
        exp_t nx;
        nx = cur;
        nx.hc = (cur.v && cur.o && cur.hc != 8'hFF) ? cur.hc + 8'd1 : cur.hc;
        if (clr) begin
            win.delete();
            nacc = 0;
            nx.v = 0; nx.o = 0; nx.c = '0; nx.hc = '0;
        end else if (v) begin
            win.push_back($countones(b) >= MINO);
            if (win.size() > DEP) void'(win.pop_front());
            if (nacc < DEP) nacc++;
            sum = 0;
            foreach (win[i]) sum += int'(win[i]);
            nx.c = CW'(sum);
            nx.o = (sum >= TH);
            nx.v = (nacc >= DEP);
        end else begin
            nx.v = 0;
        end
        cur = nx;
    endfunction

    // One clock of stimulus; inputs change on the falling edge
    task automatic step(input logic v, input logic [NB-1:0] b, input logic clr);
        @(negedge clk);
        bus.in_val = v; bus.in_bits = b; bus.clear = clr;
        if (!rst_n) model_reset();
        else        model_edge(v, b, clr);
        sb_q.push_back(cur);
    endtask

    task automatic check_now(input string name);
        checks++;
        if (bus.out_val !== 1'b0 || bus.out !== 1'b0 || bus.count !== '0
`ifdef PAIR_TRIPLE_HIT_CNT_EN
            || bus.hit_cnt !== 8'd0
`endif
            ) begin
            errors++;
            $display("FAIL %s: got v=%0b o=%0b c=%0d, required all zero",
                     name, bus.out_val, bus.out, bus.count);
        end
    endtask

    // Monitor: compare DUT outputs after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.out_val !== e.v || bus.out !== e.o || bus.count !== e.c
`ifdef PAIR_TRIPLE_HIT_CNT_EN
                    || bus.hit_cnt !== e.hc
`endif
                    ) begin
                    errors++;
                    $display("FAIL out_check t=%0t: got v=%0b o=%0b c=%0d, required v=%0b o=%0b c=%0d",
                             $time, bus.out_val, bus.out, bus.count, e.v, e.o, e.c);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_val = 0; bus.in_bits = '0; bus.clear = 0;
        model_reset();

        // Reset held with toggling inputs, then released between edges
        for (int i = 0; i < 4; i++)
            step(1'($urandom), NB'($urandom), 1'($urandom));
        check_now("in_reset");
        @(negedge clk);
        bus.in_val = 0; bus.clear = 0;
        #2 rst_n = 1'b1;
        check_now("reset_release");
        sb_q.push_back(cur);
        step(0, '0, 0);

        // Fill: 011,000,000 then 111 completes the window with two hits
        step(1, 3'b011, 0);
        step(1, 3'b000, 0);
        step(1, 3'b000, 0);
        step(1, 3'b111, 0);
        // Eviction of the first hit, then a new hit
        step(1, 3'b000, 0);
        step(1, 3'b110, 0);
        // Idle cycles in RUN hold count/out, then resume
        for (int i = 0; i < 3; i++) step(0, 3'b111, 0);
        step(1, 3'b001, 0);
        // Clear wins over a simultaneous valid sample; refill from empty
        step(1, 3'b111, 1);
        step(1, 3'b111, 0);
        step(1, 3'b101, 0);
        step(1, 3'b100, 0);
        step(1, 3'b010, 0);
        step(1, 3'b011, 0);

        // Randomised traffic
        for (int i = 0; i < 300; i++)
            step(($urandom % 10) < 7, NB'($urandom), ($urandom % 25) == 0);

        // Async reset pulse mid-RUN with count=3
        step(1, 3'b111, 1);
        step(1, 3'b111, 0);
        step(1, 3'b111, 0);
        step(1, 3'b111, 0);
        step(1, 3'b000, 0);
        step(0, 3'b000, 0);
        @(negedge clk);
        bus.in_val = 0; bus.clear = 0;
        #1 rst_n = 1'b0;
        #1 check_now("async_reset");
        #1 rst_n = 1'b1;
        model_reset();
        sb_q.push_back(cur);

`ifdef PAIR_TRIPLE_HIT_CNT_EN
        // 300 consecutive hit cycles drive hit_cnt into saturation
        for (int i = 0; i < 304; i++) step(1, 3'b111, 0);
        step(0, 3'b000, 0);
        checks++;
        if (cur.hc != 8'hFF) begin
            errors++;
            $display("FAIL hc_model_sat: model hit_cnt=%0d, required 255", cur.hc);
        end
`endif

        step(0, '0, 0);
        step(0, '0, 0);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
